// File: rtl/divider_fu.sv
// Radix-2 restoring RV32M DIV/DIVU/REM/REMU unit: result after WIDTH+1 cycles (1 cycle for div-by-zero/overflow).
// The result is held on cdb_req_out until cdb_grant_in; dispatches are accepted only in IDLE.
module divider_fu #(
    parameter int ROB_IX = 2,
    parameter int WIDTH  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  rval1_in,
    input  logic [WIDTH-1:0]  rval2_in,
    input  logic [3:0]        opcode_in,
    input  logic [ROB_IX:0]   rob_ix_in,
    input  logic              cdb_grant_in,
    output logic              fu_busy_out,
    output logic              cdb_req_out,
    output logic [WIDTH-1:0]  result_out,
    output logic [ROB_IX:0]   rob_ix_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic            is_rem;
        logic            neg_q;
        logic            neg_r;
        logic [ROB_IX:0] tag;
    } op_meta_t;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    op_meta_t         meta;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] quo;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dvs;

    // Dispatch decode
    logic             is_signed;
    logic             is_rem;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] special_res;

    logic unused_opcode_hi;
    assign unused_opcode_hi = ^opcode_in[3:2];

    always_comb begin
        is_signed   = ~opcode_in[0];
        is_rem      = opcode_in[1];
        a_neg       = is_signed & rval1_in[WIDTH-1];
        b_neg       = is_signed & rval2_in[WIDTH-1];
        a_mag       = a_neg ? -rval1_in : rval1_in;
        b_mag       = b_neg ? -rval2_in : rval2_in;
        div_zero    = (rval2_in == '0);
        ovf         = is_signed & (rval1_in == {1'b1, {(WIDTH-1){1'b0}}}) & (rval2_in == '1);
        special_res = '0;
        if (div_zero)
            special_res = is_rem ? rval1_in : '1;
        else if (ovf)
            special_res = is_rem ? '0 : rval1_in;
    end

    // One restoring step on a WIDTH+1-bit partial remainder
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] fin_res;

    always_comb begin
        shifted  = {prem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        q_bit    = ~trial[WIDTH];
        next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_quo = {quo[WIDTH-2:0], q_bit};
        if (meta.is_rem)
            fin_res = meta.neg_r ? -next_rem : next_rem;
        else
            fin_res = meta.neg_q ? -next_quo : next_quo;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            count      <= '0;
            meta       <= '0;
            prem       <= '0;
            quo        <= '0;
            dvs        <= '0;
            result_out <= '0;
            rob_ix_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (div_zero || ovf) begin
                            result_out <= special_res;
                            rob_ix_out <= rob_ix_in;
                            state      <= ST_DONE;
                        end else begin
                            meta  <= '{is_rem: is_rem, neg_q: a_neg ^ b_neg,
                                       neg_r: a_neg, tag: rob_ix_in};
                            prem  <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            count <= CW'(WIDTH - 1);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    prem  <= next_rem;
                    quo   <= next_quo;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result_out <= fin_res;
                        rob_ix_out <= meta.tag;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cdb_grant_in)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fu_busy_out = (state != ST_IDLE);
    assign cdb_req_out = (state == ST_DONE);

endmodule
